// File: rtl/round_robin_arbiter_variable_time_slice.sv
// Four-requester round-robin arbiter in which each requester owns the grant
// for up to its own time slice. GNT is registered and one-hot, or zero when idle.
module round_robin_arbiter_variable_time_slice #(
    parameter int SLICE_0 = 1,
    parameter int SLICE_1 = 2,
    parameter int SLICE_2 = 3,
    parameter int SLICE_3 = 4,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] REQ,
    output logic [3:0] GNT
);

    logic [3:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [1:0]       owner_idx;
    logic [2:0]       win_from_ptr;
    logic [2:0]       win_from_next;

    // Returns {found, index} for the first request at or after start, wrapping mod 4.
    function automatic logic [2:0] rr_search(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] slice_last(input logic [1:0] idx);
        logic [CNT_W-1:0] lim;
        case (idx)
            2'd0:    lim = CNT_W'(SLICE_0 - 1);
            2'd1:    lim = CNT_W'(SLICE_1 - 1);
            2'd2:    lim = CNT_W'(SLICE_2 - 1);
            default: lim = CNT_W'(SLICE_3 - 1);
        endcase
        return lim;
    endfunction

    always_comb begin
        owner_idx = 2'd0;
        case (gnt_q)
            4'b0010: owner_idx = 2'd1;
            4'b0100: owner_idx = 2'd2;
            4'b1000: owner_idx = 2'd3;
            default: owner_idx = 2'd0;
        endcase
    end

    // The owner is scanned last when searching from owner+1, so a sole requester re-arms.
    assign win_from_ptr  = rr_search(REQ, ptr_q);
    assign win_from_next = rr_search(REQ, owner_idx + 2'd1);

    always_comb begin
        gnt_d = gnt_q;
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        if (gnt_q == 4'b0000) begin
            if (win_from_ptr[2]) begin
                gnt_d = 4'b0001 << win_from_ptr[1:0];
                cnt_d = '0;
                ptr_d = win_from_ptr[1:0] + 2'd1;
            end
        end else if (!REQ[owner_idx] || (cnt_q == slice_last(owner_idx))) begin
            cnt_d = '0;
            if (win_from_next[2]) begin
                gnt_d = 4'b0001 << win_from_next[1:0];
                ptr_d = win_from_next[1:0] + 2'd1;
            end else begin
                gnt_d = 4'b0000;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q <= 4'b0000;
            cnt_q <= '0;
            ptr_q <= 2'd0;
        end else begin
            gnt_q <= gnt_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
        end
    end

    assign GNT = gnt_q;

endmodule

// File: tb/tb_round_robin_arbiter_variable_time_slice.sv
// Scoreboard bench: stimulus pushes expected grants from a slice-based reference
// model, a monitor pops and compares them one edge later.
module tb_round_robin_arbiter_variable_time_slice;

    logic       clk;
    logic       rst_n;
    logic [3:0] REQ;
    logic [3:0] GNT;

    int test_count = 0;
    int fail_count = 0;

    logic [3:0] exp_q[$];

    int slices[4] = '{1, 2, 3, 4};
    int m_owner;
    int m_used;
    int m_ptr;

    round_robin_arbiter_variable_time_slice #(
        .SLICE_0(1), .SLICE_1(2), .SLICE_2(3), .SLICE_3(4), .CNT_W(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .REQ  (REQ),
        .GNT  (GNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        test_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic int search(input logic [3:0] r, input int s);
        for (int i = 0; i < 4; i++) begin
            if (r[(s + i) % 4]) return (s + i) % 4;
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_owner = -1;
        m_used  = 0;
        m_ptr   = 0;
    endtask

    task automatic modelGrant(input int w);
        if (w < 0) begin
            m_owner = -1;
            m_used  = 0;
        end else begin
            m_owner = w;
            m_used  = 1;
            m_ptr   = (w + 1) % 4;
        end
    endtask

    // One edge of the reference: m_used counts cycles the owner has already held.
    task automatic modelStep(input logic [3:0] r);
        if (m_owner < 0) begin
            if (r != 4'b0000) modelGrant(search(r, m_ptr));
        end else if (!r[m_owner] || m_used == slices[m_owner]) begin
            modelGrant(search(r, (m_owner + 1) % 4));
        end else begin
            m_used++;
        end
    endtask

    function automatic logic [3:0] modelGnt();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic driveNow(input logic [3:0] r);
        REQ = r;
        modelStep(r);
        exp_q.push_back(modelGnt());
    endtask

    task automatic applyStimulus(input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            driveNow(r);
        end
    endtask

    // Monitor: checks the grant registered at each edge against the scoreboard.
    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("gnt", GNT, e);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [3:0] r;
        modelReset();
        rst_n = 1'b0;
        REQ   = 4'b1111;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_hold", GNT, 4'b0000);

        @(negedge clk);
        rst_n = 1'b1;
        driveNow(4'b1111);
        applyStimulus(4'b1111, 10);

        applyStimulus(4'b0000, 2);
        applyStimulus(4'b1000, 10);
        applyStimulus(4'b1010, 14);

        applyStimulus(4'b0000, 2);
        applyStimulus(4'b0110, 4);
        applyStimulus(4'b0010, 1);
        applyStimulus(4'b0000, 2);

        applyStimulus(4'b0100, 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", GNT, 4'b0000);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        driveNow(4'b0010);
        applyStimulus(4'b0010, 3);

        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            applyStimulus(r, 1);
        end

        applyStimulus(4'b0000, 2);
        repeat (2) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            test_count++;
            fail_count++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
